inst_fetch: RTL



---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// inst_fetch_pkg : shared widths, reset PC and fetch FSM state type
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

  localparam int          FETCH_TO_DEC_BUS_WD = 64;
  localparam int          BR_BUS_WD           = 33;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h1c000000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch : IF stage, one outstanding SRAM-like read, wrong-path cancel
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_allowin,
  input  logic [BR_BUS_WD-1:0]           branch_bus,
  output logic                           fetch_to_dec_valid,
  output logic [FETCH_TO_DEC_BUS_WD-1:0] fetch_to_decode_bus,
  output logic                           inst_sram_req,
  output logic                           inst_sram_wr,
  output logic [1:0]                     inst_sram_size,
  output logic [3:0]                     inst_sram_wstrb,
  output logic [31:0]                    inst_sram_addr,
  output logic [31:0]                    inst_sram_wdata,
  input  logic                           inst_sram_addr_ok,
  input  logic                           inst_sram_data_ok,
  input  logic [31:0]                    inst_sram_rdata
);

  fetch_state_e state, state_nxt;
  logic [31:0]  req_pc, req_pc_nxt;
  logic [31:0]  fs_pc, fs_pc_nxt;
  logic [31:0]  fs_inst, fs_inst_nxt;
  logic         cancel, cancel_nxt;

  logic         br_taken;
  logic [31:0]  br_target;
  logic         br_fire;

  assign br_taken  = branch_bus[32];
  assign br_target = branch_bus[31:0];
  // dec_allowin implies decode's ready_go, so the target is trustworthy.
  assign br_fire   = br_taken & dec_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      req_pc  <= RESET_PC;
      fs_pc   <= 32'd0;
      fs_inst <= 32'd0;
      cancel  <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_pc  <= req_pc_nxt;
      fs_pc   <= fs_pc_nxt;
      fs_inst <= fs_inst_nxt;
      cancel  <= cancel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_pc_nxt  = req_pc;
    fs_pc_nxt   = fs_pc;
    fs_inst_nxt = fs_inst;
    cancel_nxt  = cancel;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (br_fire) begin
          req_pc_nxt = br_target;
        end
        if (inst_sram_addr_ok) begin
          state_nxt  = S_WAIT;
          // The accepted request targets the old address when redirected.
          cancel_nxt = br_fire;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          cancel_nxt = 1'b0;
          if (br_fire) begin
            req_pc_nxt = br_target;
            state_nxt  = S_REQ;
          end else if (cancel) begin
            state_nxt  = S_REQ;
          end else begin
            fs_inst_nxt = inst_sram_rdata;
            fs_pc_nxt   = req_pc;
            req_pc_nxt  = req_pc + 32'd4;
            state_nxt   = S_VALID;
          end
        end else if (br_fire) begin
          cancel_nxt = 1'b1;
          req_pc_nxt = br_target;
        end
      end
      S_VALID: begin
        if (br_fire) begin
          req_pc_nxt = br_target;
          state_nxt  = S_REQ;
        end else if (dec_allowin) begin
          state_nxt  = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign inst_sram_req       = (state == S_REQ);
  assign inst_sram_addr      = req_pc;
  assign inst_sram_wr        = 1'b0;
  assign inst_sram_size      = 2'd2;
  assign inst_sram_wstrb     = 4'd0;
  assign inst_sram_wdata     = 32'd0;
  assign fetch_to_dec_valid  = (state == S_VALID);
  assign fetch_to_decode_bus = {fs_inst, fs_pc};

endmodule

`default_nettype wire
